// File: rtl/seq_detect_ctrl_if.sv
// Bundle between the configuration/CPU side plus serial stream and the
// pattern-detection session controller. The controller uses the slave
// modport; whatever drives configuration and bits uses the master modport.
interface seq_detect_ctrl_if #(
    parameter int MAX_LEN  = 8,
    parameter int LEN_W    = 4,
    parameter int CNT_W    = 8,
    parameter int BUDGET_W = 16
);

    // Configuration, sampled only when a session is accepted
    logic [MAX_LEN-1:0]  cfg_pattern;
    logic [LEN_W-1:0]    cfg_len;
    logic [CNT_W-1:0]    cfg_target;
    logic [BUDGET_W-1:0] cfg_budget;

    // Session control and serial stream
    logic                start;
    logic                abort;
    logic                x;
    logic                x_valid;

    // Session results
    logic                busy;
    logic                z;
    logic [CNT_W-1:0]    match_count;
    logic [BUDGET_W-1:0] bits_seen;
    logic                done;
    logic [1:0]          status;

    modport master (
        output cfg_pattern,
        output cfg_len,
        output cfg_target,
        output cfg_budget,
        output start,
        output abort,
        output x,
        output x_valid,
        input  busy,
        input  z,
        input  match_count,
        input  bits_seen,
        input  done,
        input  status
    );

    modport slave (
        input  cfg_pattern,
        input  cfg_len,
        input  cfg_target,
        input  cfg_budget,
        input  start,
        input  abort,
        input  x,
        input  x_valid,
        output busy,
        output z,
        output match_count,
        output bits_seen,
        output done,
        output status
    );

endinterface

// File: rtl/seq_detect_ctrl.sv
// Session controller for serial bit-pattern detection.
// A session latches a pattern of 1..MAX_LEN bits, spends one cycle arming,
// then counts overlapping matches on qualified serial bits until the match
// target is reached, the bit budget runs out, or software aborts.
// Every output comes straight from a flop.
module seq_detect_ctrl #(
    parameter int MAX_LEN  = 8,
    parameter int LEN_W    = 4,
    parameter int CNT_W    = 8,
    parameter int BUDGET_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    seq_detect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // End-of-session cause codes reported on status
    localparam logic [1:0] END_CFG_ERR = 2'b00;
    localparam logic [1:0] END_TARGET  = 2'b01;
    localparam logic [1:0] END_BUDGET  = 2'b10;
    localparam logic [1:0] END_ABORT   = 2'b11;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t              state_q,       state_d;

    // Latched session configuration
    logic [MAX_LEN-1:0]  pattern_q,     pattern_d;
    logic [LEN_W-1:0]    len_q,         len_d;
    logic [CNT_W-1:0]    target_q,      target_d;
    logic [BUDGET_W-1:0] budget_q,      budget_d;

    // Only the previous MAX_LEN-1 bits need storing: the bit arriving this
    // cycle completes a full MAX_LEN-bit comparison window.
    logic [MAX_LEN-2:0]  history_q,     history_d;

    // Number of valid bits in the window, saturating at the pattern length
    logic [LEN_W-1:0]    fill_q,        fill_d;

    // Registered outputs
    logic                busy_q,        busy_d;
    logic                z_q,           z_d;
    logic                done_q,        done_d;
    logic [CNT_W-1:0]    match_count_q, match_count_d;
    logic [BUDGET_W-1:0] bits_seen_q,   bits_seen_d;
    logic [1:0]          status_q,      status_d;

    // ---------------------------------------------------------------
    // Datapath helpers
    // ---------------------------------------------------------------
    logic                cfg_ok;
    logic [MAX_LEN-1:0]  len_mask;
    logic [MAX_LEN-1:0]  hist_shift;
    logic [LEN_W-1:0]    fill_inc;
    logic [BUDGET_W-1:0] bits_inc;
    logic                match_hit;
    logic [CNT_W-1:0]    count_inc;
    logic                hit_target;
    logic                hit_budget;

    // A session may start only with a usable length and a non-zero target
    assign cfg_ok = (bus.cfg_len != '0) &&
                    (bus.cfg_len <= MAX_LEN_L) &&
                    (bus.cfg_target != '0);

    // Select the low len_q bits of the window for comparison
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
            assign len_mask[gi] = (len_q > LEN_W'(gi));
        end
    endgenerate

    // Window including the bit presented this cycle, newest bit at [0]
    assign hist_shift = {history_q, bus.x};

    // Fill counter saturates at the pattern length so it never wraps on
    // long sessions; matching only needs "window full".
    assign fill_inc = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);

    assign bits_inc = bits_seen_q + BUDGET_W'(1);

    // History is never cleared on a match, so overlapping matches are found
    assign match_hit = (fill_inc == len_q) &&
                       (((hist_shift ^ pattern_q) & len_mask) == '0);

    assign count_inc = match_count_q + CNT_W'(match_hit);

    // Target wins over budget when both land on the same bit
    assign hit_target = (count_inc == target_q);
    assign hit_budget = (budget_q != '0) && (bits_inc == budget_q);

    // ---------------------------------------------------------------
    // Next-state and next-output logic for the session FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        len_d         = len_q;
        target_d      = target_q;
        budget_d      = budget_q;
        history_d     = history_q;
        fill_d        = fill_q;
        busy_d        = busy_q;
        z_d           = 1'b0;
        done_d        = 1'b0;
        match_count_d = match_count_q;
        bits_seen_d   = bits_seen_q;
        status_d      = status_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (cfg_ok) begin
                        pattern_d = bus.cfg_pattern;
                        len_d     = bus.cfg_len;
                        target_d  = bus.cfg_target;
                        budget_d  = bus.cfg_budget;
                        busy_d    = 1'b1;
                        state_d   = ST_ARM;
                    end else begin
                        // Bad configuration is reported without ever going busy
                        status_d  = END_CFG_ERR;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end

            ST_ARM: begin
                history_d     = '0;
                fill_d        = '0;
                match_count_d = '0;
                bits_seen_d   = '0;
                if (bus.abort) begin
                    status_d = END_ABORT;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.abort) begin
                    // A bit arriving with abort is dropped entirely
                    status_d = END_ABORT;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_DONE;
                end else if (bus.x_valid) begin
                    history_d     = hist_shift[MAX_LEN-2:0];
                    fill_d        = fill_inc;
                    bits_seen_d   = bits_inc;
                    match_count_d = count_inc;
                    z_d           = match_hit;
                    if (hit_target) begin
                        status_d = END_TARGET;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = ST_DONE;
                    end else if (hit_budget) begin
                        status_d = END_BUDGET;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Session FSM and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pattern_q     <= '0;
            len_q         <= '0;
            target_q      <= '0;
            budget_q      <= '0;
            history_q     <= '0;
            fill_q        <= '0;
            busy_q        <= 1'b0;
            z_q           <= 1'b0;
            done_q        <= 1'b0;
            match_count_q <= '0;
            bits_seen_q   <= '0;
            status_q      <= END_CFG_ERR;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            len_q         <= len_d;
            target_q      <= target_d;
            budget_q      <= budget_d;
            history_q     <= history_d;
            fill_q        <= fill_d;
            busy_q        <= busy_d;
            z_q           <= z_d;
            done_q        <= done_d;
            match_count_q <= match_count_d;
            bits_seen_q   <= bits_seen_d;
            status_q      <= status_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.z           = z_q;
    assign bus.done        = done_q;
    assign bus.match_count = match_count_q;
    assign bus.bits_seen   = bits_seen_q;
    assign bus.status      = status_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed vector table, hand-written reset and
// multi-cycle sequences, and randomized sessions against a stream model.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN  = 8;
    localparam int LEN_W    = 4;
    localparam int CNT_W    = 8;
    localparam int BUDGET_W = 16;

    logic clk = 1'b0;
    logic reset;

    seq_detect_ctrl_if #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .BUDGET_W(BUDGET_W)
    ) ifc ();

    seq_detect_ctrl #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .BUDGET_W(BUDGET_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // One cycle of stimulus with the outputs expected after that edge
    typedef struct {
        logic        start, abort, xv, x;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [7:0]  tgt;
        logic [15:0] bud;
        logic        eb, ez, ed;
        int          emc, ebits, est;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  c_pat;
    logic [3:0]  c_len;
    logic [7:0]  c_tgt;
    logic [15:0] c_bud;
    string       c_name;

    function automatic void add(input logic st, ab, xv, xb, eb, ez, ed,
                                input int emc, ebits, est);
        vec_t v;
        v.start = st; v.abort = ab; v.xv = xv; v.x = xb;
        v.pat = c_pat; v.len = c_len; v.tgt = c_tgt; v.bud = c_bud;
        v.eb = eb; v.ez = ez; v.ed = ed;
        v.emc = emc; v.ebits = ebits; v.est = est;
        v.name = c_name;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic eb, ez, ed,
                            input int emc, ebits, est);
        chk({tag, ".busy"},   32'(ifc.busy),        32'(eb));
        chk({tag, ".z"},      32'(ifc.z),           32'(ez));
        chk({tag, ".done"},   32'(ifc.done),        32'(ed));
        chk({tag, ".mcount"}, 32'(ifc.match_count), emc);
        chk({tag, ".bits"},   32'(ifc.bits_seen),   ebits);
        chk({tag, ".status"}, 32'(ifc.status),      est);
    endtask

    task automatic drive_cycle(input logic st, ab, xv, xb);
        @(negedge clk);
        ifc.start   = st;
        ifc.abort   = ab;
        ifc.x_valid = xv;
        ifc.x       = xb;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stream reference model ----------------
    // Phase: 0 idle, 1 arming, 2 running, 3 reporting.
    int         m_phase;
    bit         acc[$];
    logic [7:0] m_pat;
    int         m_len, m_tgt, m_bud;
    int         e_mc, e_bits, e_status;
    bit         e_busy, e_z, e_done;

    function automatic void model_reset();
        m_phase = 0; acc.delete();
        e_mc = 0; e_bits = 0; e_status = 0;
        e_busy = 0; e_z = 0; e_done = 0;
    endfunction

    function automatic void end_session(input int s);
        m_phase  = 3;
        e_done   = 1;
        e_status = s;
    endfunction

    // Do the last m_len accepted bits spell the pattern (bit 0 = newest)?
    function automatic bit window_hit();
        if (acc.size() < m_len) return 1'b0;
        for (int j = 0; j < m_len; j++)
            if (acc[acc.size() - 1 - j] != m_pat[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic st, ab, xv, xb);
        e_z = 0; e_done = 0;
        case (m_phase)
            0: if (st) begin
                if (ifc.cfg_len >= 1 && int'(ifc.cfg_len) <= MAX_LEN && ifc.cfg_target != 0) begin
                    m_pat = ifc.cfg_pattern; m_len = int'(ifc.cfg_len);
                    m_tgt = int'(ifc.cfg_target); m_bud = int'(ifc.cfg_budget);
                    m_phase = 1;
                end else begin
                    end_session(0);
                end
            end
            1: begin
                acc.delete(); e_mc = 0; e_bits = 0;
                if (ab) end_session(3); else m_phase = 2;
            end
            2: if (ab) begin
                end_session(3);
            end else if (xv) begin
                acc.push_back(xb);
                if (acc.size() > 16) void'(acc.pop_front());
                e_bits++;
                if (window_hit()) begin e_z = 1; e_mc++; end
                if (e_mc == m_tgt) end_session(1);
                else if (m_bud != 0 && e_bits == m_bud) end_session(2);
            end
            default: m_phase = 0;
        endcase
        e_busy = (m_phase == 1 || m_phase == 2);
    endtask

    task automatic mcycle(input logic st, ab, xv, xb);
        drive_cycle(st, ab, xv, xb);
        model_step(st, ab, xv, xb);
        chk_outs("model", e_busy, e_z, e_done, e_mc, e_bits, e_status);
        if (e_done)
            $display("session end: status=%0d matches=%0d bits=%0d", e_status, e_mc, e_bits);
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [3:0] l,
                           input logic [7:0] t, input logic [15:0] b);
        ifc.cfg_pattern = p; ifc.cfg_len = l; ifc.cfg_target = t; ifc.cfg_budget = b;
    endtask

    // Hard stop in case anything stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        reset = 1'b1;
        set_cfg(8'h00, 4'd0, 8'd0, 16'd0);
        ifc.start = 0; ifc.abort = 0; ifc.x = 0; ifc.x_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- vector table ----------------
        // Invalid configurations: len 0, target 0, len above MAX_LEN
        c_name = "cfg_len0"; c_pat = 8'h05; c_len = 4'd0; c_tgt = 8'd1; c_bud = 16'd0;
        add(1, 0, 0, 0,  0, 0, 1,  0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        c_name = "cfg_tgt0"; c_len = 4'd3; c_tgt = 8'd0;
        add(1, 0, 0, 0,  0, 0, 1,  0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        c_name = "cfg_len9"; c_len = 4'd9; c_tgt = 8'd1;
        add(1, 0, 0, 0,  0, 0, 1,  0, 0, 0);

        // 110011 len 6 target 2: start ignored in DONE, accepted next cycle
        c_name = "p110011"; c_pat = 8'b0011_0011; c_len = 4'd6; c_tgt = 8'd2; c_bud = 16'd0;
        add(1, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        add(1, 0, 0, 0,  1, 0, 0,  0, 0, 0);
        // Configuration changes after acceptance must not matter
        c_pat = 8'hFF; c_len = 4'd1; c_tgt = 8'd1; c_bud = 16'd1;
        add(0, 0, 1, 1,  1, 0, 0,  0, 0, 0);   // ARM: bit ignored
        add(0, 0, 1, 1,  1, 0, 0,  0, 1, 0);
        add(0, 0, 1, 1,  1, 0, 0,  0, 2, 0);
        add(0, 0, 1, 0,  1, 0, 0,  0, 3, 0);
        add(0, 0, 1, 0,  1, 0, 0,  0, 4, 0);
        add(0, 0, 1, 1,  1, 0, 0,  0, 5, 0);
        add(0, 0, 1, 1,  1, 1, 0,  1, 6, 0);
        add(0, 0, 1, 0,  1, 0, 0,  1, 7, 0);
        add(0, 0, 1, 0,  1, 0, 0,  1, 8, 0);
        add(0, 0, 1, 1,  1, 0, 0,  1, 9, 0);
        add(0, 0, 1, 1,  0, 1, 1,  2, 10, 1);
        add(0, 0, 1, 1,  0, 0, 0,  2, 10, 1);  // DONE ignores bits
        add(0, 1, 1, 1,  0, 0, 0,  2, 10, 1);  // IDLE ignores abort/bits

        // 11 len 2 target 1 budget 2: target beats budget on the same bit
        c_name = "p11"; c_pat = 8'b11; c_len = 4'd2; c_tgt = 8'd1; c_bud = 16'd2;
        add(1, 0, 0, 0,  1, 0, 0,  2, 10, 1);
        add(0, 0, 0, 0,  1, 0, 0,  0, 0, 1);
        add(0, 0, 1, 1,  1, 0, 0,  0, 1, 1);
        add(0, 0, 1, 1,  0, 1, 1,  1, 2, 1);
        add(0, 0, 0, 0,  0, 0, 0,  1, 2, 1);

        // Config error after a session: status changes, counters hold
        c_name = "cfg_err_hold"; c_len = 4'd0;
        add(1, 0, 0, 0,  0, 0, 1,  1, 2, 0);
        add(0, 0, 0, 0,  0, 0, 0,  1, 2, 0);

        // Abort with a same-cycle bit that would otherwise complete a match
        c_name = "abort"; c_pat = 8'b0011; c_len = 4'd4; c_tgt = 8'd1; c_bud = 16'd0;
        add(1, 0, 0, 0,  1, 0, 0,  1, 2, 0);
        add(0, 0, 0, 0,  1, 0, 0,  0, 0, 0);
        add(0, 0, 1, 0,  1, 0, 0,  0, 1, 0);
        add(0, 0, 1, 0,  1, 0, 0,  0, 2, 0);
        add(0, 0, 1, 1,  1, 0, 0,  0, 3, 0);
        add(0, 1, 1, 1,  0, 0, 1,  0, 3, 3);
        add(0, 0, 0, 0,  0, 0, 0,  0, 3, 3);

        // Abort during the ARM cycle
        c_name = "abort_arm";
        add(1, 0, 0, 0,  1, 0, 0,  0, 3, 3);
        add(0, 1, 0, 0,  0, 0, 1,  0, 0, 3);
        add(0, 0, 0, 0,  0, 0, 0,  0, 0, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            set_cfg(vecs[i].pat, vecs[i].len, vecs[i].tgt, vecs[i].bud);
            ifc.start   = vecs[i].start;
            ifc.abort   = vecs[i].abort;
            ifc.x_valid = vecs[i].xv;
            ifc.x       = vecs[i].x;
            @(posedge clk);
            #1;
            chk_outs(vecs[i].name, vecs[i].eb, vecs[i].ez, vecs[i].ed,
                     vecs[i].emc, vecs[i].ebits, vecs[i].est);
            $display("vec %0d %s: busy=%0b z=%0b done=%0b mc=%0d bits=%0d status=%0d",
                     i, vecs[i].name, ifc.busy, ifc.z, ifc.done,
                     ifc.match_count, ifc.bits_seen, ifc.status);
        end

        // ---------------- asynchronous reset mid-RUN ----------------
        set_cfg(8'h01, 4'd1, 8'd5, 16'd0);
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 1, 1);
        drive_cycle(0, 0, 1, 1);
        chk_outs("pre_reset", 1, 1, 0, 2, 2, 3);
        #2 reset = 1'b1;
        #1;
        chk_outs("async_reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_outs("reset_hold", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Pattern 1 len 1 target 3 on stream 111
        set_cfg(8'h01, 4'd1, 8'd3, 16'd0);
        mcycle(1, 0, 0, 0);
        mcycle(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) mcycle(0, 0, 1, 1);
        chk("len1.status", 32'(ifc.status), 32'd1);
        chk("len1.mcount", 32'(ifc.match_count), 32'd3);
        mcycle(0, 0, 0, 0);

        // Pattern 101 target 5 budget 8 on zeros with random bubbles
        set_cfg(8'b101, 4'd3, 8'd5, 16'd8);
        mcycle(1, 0, 0, 0);
        mcycle(0, 0, 0, 0);
        for (int k = 0; k < 200 && !e_done; k++)
            mcycle(0, 0, logic'($urandom_range(0, 2) != 0), 1'b0);
        chk("budget.ended", 32'(e_done), 32'd1);
        chk("budget.status", 32'(ifc.status), 32'd2);
        chk("budget.bits", 32'(ifc.bits_seen), 32'd8);
        chk("budget.mcount", 32'(ifc.match_count), 32'd0);
        mcycle(0, 0, 0, 0);

        // ---------------- randomized sessions ----------------
        for (int c = 0; c < 5000; c++) begin
            int r;
            logic [3:0] l;
            r = $urandom_range(0, 15);
            if (r == 0)      l = 4'd0;
            else if (r == 1) l = 4'($urandom_range(9, 15));
            else if (r < 9)  l = 4'($urandom_range(1, 3));
            else             l = 4'($urandom_range(1, 8));
            set_cfg(8'($urandom), l,
                    ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 3)),
                    ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 24)));
            mcycle(logic'($urandom_range(0, 3) == 0),
                   logic'($urandom_range(0, 49) == 0),
                   logic'($urandom_range(0, 3) != 0),
                   logic'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
